// File: rtl/regwrite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regwrite_pkg
// Description : Shared sizes and the write-request record used by the
//               register-file write-port arbiter and its result FIFO.
// Contents    : NREG, REG_AW, DATA_W, wb_req_t {wa, wd}
// Revision    : 1.0 - initial release
// ============================================================================
package regwrite_pkg;

  localparam int NREG   = 32;
  localparam int REG_AW = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [REG_AW-1:0] wa;
    logic [DATA_W-1:0] wd;
  } wb_req_t;

endpackage : regwrite_pkg
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : DEPTH-entry synchronous FIFO of wb_req_t holding completed
//               mult/div results until the write port is free.
// Ports       : clk_i, rst_n_i (sync, active-low)
//               push_i/push_data_i  - enqueue at tail (ignored when full)
//               pop_i               - dequeue head (ignored when empty)
//               head_o              - current head entry
//               full_o, empty_o     - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
  import regwrite_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk_i,
  input  logic    rst_n_i,
  input  logic    push_i,
  input  wb_req_t push_data_i,
  input  logic    pop_i,
  output wb_req_t head_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;

  wb_req_t           mem_q [DEPTH];
  logic [c_AW-1:0]   wr_ptr_q;
  logic [c_AW-1:0]   rd_ptr_q;
  // One extra bit so a full FIFO is distinguishable from an empty one
  // when both pointers coincide.
  logic [c_CW-1:0]   count_q;

  logic w_push;
  logic w_pop;

  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign full_o  = (count_q == c_CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule : wb_fifo
`default_nettype wire

// File: rtl/regwrite_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regwrite_arbiter
// Description : Shares the register-file write port between the pipeline
//               writeback stage (priority) and buffered mult/div results,
//               and tracks registers with mult/div results still in flight.
// Ports       : clk_i, rst_n_i (sync, active-low), halt_i (freeze)
//               pipe_we_i/pipe_wa_i/pipe_wd_i    - pipeline writeback
//               md_issue_i/md_issue_wa_i         - mult/div issue (sets pending)
//               md_valid_i/md_ready_o/md_wa_i/md_wd_i - mult/div result
//               chk_ra1_i/chk_ra2_i/chk_wa_i     - decode hazard probe
//               stall_o                           - decode hazard
//               rf_we_o/rf_wa_o/rf_wd_o          - register-file write port
//               pending_o                         - scoreboard, bit 0 always 0
// Revision    : 1.0 - initial release
// ============================================================================
module regwrite_arbiter
  import regwrite_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              halt_i,
  input  logic              pipe_we_i,
  input  logic [REG_AW-1:0] pipe_wa_i,
  input  logic [DATA_W-1:0] pipe_wd_i,
  input  logic              md_issue_i,
  input  logic [REG_AW-1:0] md_issue_wa_i,
  input  logic              md_valid_i,
  output logic              md_ready_o,
  input  logic [REG_AW-1:0] md_wa_i,
  input  logic [DATA_W-1:0] md_wd_i,
  input  logic [REG_AW-1:0] chk_ra1_i,
  input  logic [REG_AW-1:0] chk_ra2_i,
  input  logic [REG_AW-1:0] chk_wa_i,
  output logic              stall_o,
  output logic              rf_we_o,
  output logic [REG_AW-1:0] rf_wa_o,
  output logic [DATA_W-1:0] rf_wd_o,
  output logic [NREG-1:0]   pending_o
);

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;

  wb_req_t w_push_data;
  wb_req_t w_head;
  logic    w_full;
  logic    w_empty;
  logic    w_active;
  logic    w_pipe_win;
  logic    w_push;
  logic    w_pop;

  assign w_push_data = '{wa: md_wa_i, wd: md_wd_i};

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .push_i      (w_push),
    .push_data_i (w_push_data),
    .pop_i       (w_pop),
    .head_o      (w_head),
    .full_o      (w_full),
    .empty_o     (w_empty)
  );

  // Nothing moves while halted or held in reset.
  assign w_active   = rst_n_i && !halt_i;
  // A pipeline write to r0 is a no-op and leaves the port free for the FIFO.
  assign w_pipe_win = pipe_we_i && (pipe_wa_i != '0);

  assign md_ready_o = w_active && !w_full;
  assign w_push     = md_valid_i && md_ready_o;
  assign w_pop      = w_active && !w_empty && !w_pipe_win;

  // A popped r0 result is discarded rather than written.
  assign rf_we_o = w_active && (w_pipe_win || (w_pop && (w_head.wa != '0)));
  assign rf_wa_o = w_pipe_win ? pipe_wa_i : w_head.wa;
  assign rf_wd_o = w_pipe_win ? pipe_wd_i : w_head.wd;

  // Set is applied after clear so a re-issue to a register retiring in the
  // same cycle keeps it pending.
  always_comb begin
    pending_d = pending_q;
    if (w_active) begin
      if (w_pop) begin
        pending_d[w_head.wa] = 1'b0;
      end
      if (md_issue_i && (md_issue_wa_i != '0)) begin
        pending_d[md_issue_wa_i] = 1'b1;
      end
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;
  assign stall_o   = pending_q[chk_ra1_i] | pending_q[chk_ra2_i] | pending_q[chk_wa_i];

endmodule : regwrite_arbiter
`default_nettype wire

// File: tb/tb_regwrite_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regwrite_arbiter
// Description : Directed self-checking bench for regwrite_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regwrite_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        halt_i;
  logic        pipe_we_i;
  logic [4:0]  pipe_wa_i;
  logic [31:0] pipe_wd_i;
  logic        md_issue_i;
  logic [4:0]  md_issue_wa_i;
  logic        md_valid_i;
  logic        md_ready_o;
  logic [4:0]  md_wa_i;
  logic [31:0] md_wd_i;
  logic [4:0]  chk_ra1_i;
  logic [4:0]  chk_ra2_i;
  logic [4:0]  chk_wa_i;
  logic        stall_o;
  logic        rf_we_o;
  logic [4:0]  rf_wa_o;
  logic [31:0] rf_wd_o;
  logic [31:0] pending_o;

  int total = 0;
  int bad   = 0;

  regwrite_arbiter #(.DEPTH(2)) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .halt_i        (halt_i),
    .pipe_we_i     (pipe_we_i),
    .pipe_wa_i     (pipe_wa_i),
    .pipe_wd_i     (pipe_wd_i),
    .md_issue_i    (md_issue_i),
    .md_issue_wa_i (md_issue_wa_i),
    .md_valid_i    (md_valid_i),
    .md_ready_o    (md_ready_o),
    .md_wa_i       (md_wa_i),
    .md_wd_i       (md_wd_i),
    .chk_ra1_i     (chk_ra1_i),
    .chk_ra2_i     (chk_ra2_i),
    .chk_wa_i      (chk_wa_i),
    .stall_o       (stall_o),
    .rf_we_o       (rf_we_o),
    .rf_wa_o       (rf_wa_o),
    .rf_wd_o       (rf_wd_o),
    .pending_o     (pending_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change 1 time unit after the rising edge; checks happen there too,
  // well away from the next edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_port(input string tag, input logic we, input logic [4:0] wa,
                          input logic [31:0] wd);
    chk({tag, "_we"}, 64'(rf_we_o), 64'(we));
    if (we) begin
      chk({tag, "_wa"}, 64'(rf_wa_o), 64'(wa));
      chk({tag, "_wd"}, 64'(rf_wd_o), 64'(wd));
    end
  endtask

  initial begin
    rst_n_i = 1'b0; halt_i = 1'b0;
    pipe_we_i = 1'b0; pipe_wa_i = '0; pipe_wd_i = '0;
    md_issue_i = 1'b0; md_issue_wa_i = '0;
    md_valid_i = 1'b0; md_wa_i = '0; md_wd_i = '0;
    chk_ra1_i = '0; chk_ra2_i = '0; chk_wa_i = '0;

    // ---------------- reset ----------------
    tick();
    chk("rst_ready", 64'(md_ready_o), 64'd0);
    chk("rst_we", 64'(rf_we_o), 64'd0);
    chk("rst_pending", 64'(pending_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    tick();
    rst_n_i = 1'b1;
    #1;
    chk("rel_ready", 64'(md_ready_o), 64'd1);
    tick();
    chk("idle_we", 64'(rf_we_o), 64'd0);
    chk("idle_pending", 64'(pending_o), 64'd0);

    // ---------------- issue r5, result r5=0x1234 ----------------
    md_issue_i = 1'b1; md_issue_wa_i = 5'd5;
    tick();
    md_issue_i = 1'b0;
    chk_ra1_i = 5'd5;
    #1;
    chk("iss_pending", 64'(pending_o), 64'h20);
    chk("iss_stall", 64'(stall_o), 64'd1);
    md_valid_i = 1'b1; md_wa_i = 5'd5; md_wd_i = 32'h1234;
    #1;
    chk("push_empty_we", 64'(rf_we_o), 64'd0);
    tick();
    md_valid_i = 1'b0;
    #1;
    chk_port("md5", 1'b1, 5'd5, 32'h1234);
    chk("md5_stall_hold", 64'(stall_o), 64'd1);
    tick();
    chk("md5_pending_clr", 64'(pending_o), 64'd0);
    chk("md5_stall_clr", 64'(stall_o), 64'd0);
    chk("md5_idle_we", 64'(rf_we_o), 64'd0);
    chk_ra1_i = '0;

    // ---------------- pipeline busy 4 cycles, two results queue ----------------
    pipe_we_i = 1'b1; pipe_wa_i = 5'd3; pipe_wd_i = 32'hAA;
    md_valid_i = 1'b1; md_wa_i = 5'd7; md_wd_i = 32'h7777;
    #1;
    chk_port("pipe_c0", 1'b1, 5'd3, 32'hAA);
    tick();
    md_wa_i = 5'd8; md_wd_i = 32'h8888;
    #1;
    chk_port("pipe_c1", 1'b1, 5'd3, 32'hAA);
    chk("ready_c1", 64'(md_ready_o), 64'd1);
    tick();
    md_valid_i = 1'b0;
    #1;
    chk("full_ready", 64'(md_ready_o), 64'd0);
    chk_port("pipe_c2", 1'b1, 5'd3, 32'hAA);
    tick();
    chk_port("pipe_c3", 1'b1, 5'd3, 32'hAA);
    tick();
    pipe_we_i = 1'b0;
    #1;
    chk_port("drain_r7", 1'b1, 5'd7, 32'h7777);
    tick();
    chk_port("drain_r8", 1'b1, 5'd8, 32'h8888);
    chk("drain_ready", 64'(md_ready_o), 64'd1);
    tick();
    chk("drain_done", 64'(rf_we_o), 64'd0);

    // ---------------- pipeline write to r0 lets FIFO drain ----------------
    md_valid_i = 1'b1; md_wa_i = 5'd9; md_wd_i = 32'h55;
    tick();
    md_valid_i = 1'b0;
    pipe_we_i = 1'b1; pipe_wa_i = 5'd0; pipe_wd_i = 32'hFF;
    #1;
    chk_port("r0_drain", 1'b1, 5'd9, 32'h55);
    tick();
    pipe_we_i = 1'b0;
    #1;
    chk("r0_after", 64'(rf_we_o), 64'd0);

    // ---------------- re-issue r4 while r4 pops: set wins ----------------
    md_valid_i = 1'b1; md_wa_i = 5'd4; md_wd_i = 32'h44;
    tick();
    md_valid_i = 1'b0;
    md_issue_i = 1'b1; md_issue_wa_i = 5'd4;
    #1;
    chk_port("r4_pop", 1'b1, 5'd4, 32'h44);
    tick();
    md_issue_i = 1'b0;
    #1;
    chk("r4_set_wins", 64'(pending_o), 64'h10);

    // ---------------- halt ----------------
    md_valid_i = 1'b1; md_wa_i = 5'd10; md_wd_i = 32'h10;
    pipe_we_i = 1'b1; pipe_wa_i = 5'd3; pipe_wd_i = 32'hBB;
    tick();
    halt_i = 1'b1;
    pipe_we_i = 1'b0;
    md_wa_i = 5'd11; md_wd_i = 32'h11;
    md_issue_i = 1'b1; md_issue_wa_i = 5'd12;
    chk_ra2_i = 5'd4;
    #1;
    chk("halt_ready", 64'(md_ready_o), 64'd0);
    chk("halt_we", 64'(rf_we_o), 64'd0);
    chk("halt_stall", 64'(stall_o), 64'd1);
    tick();
    pipe_we_i = 1'b1;
    #1;
    chk("halt_pipe_we", 64'(rf_we_o), 64'd0);
    chk("halt_no_set", 64'(pending_o), 64'h10);
    halt_i = 1'b0;
    pipe_we_i = 1'b0;
    md_valid_i = 1'b0; md_issue_i = 1'b0;
    chk_ra2_i = '0;
    #1;
    chk_port("unhalt_r10", 1'b1, 5'd10, 32'h10);
    tick();
    chk("halt_no_push", 64'(rf_we_o), 64'd0);

    // ---------------- reset with entries buffered ----------------
    pipe_we_i = 1'b1; pipe_wa_i = 5'd3;
    md_valid_i = 1'b1; md_wa_i = 5'd13; md_wd_i = 32'hD;
    md_issue_i = 1'b1; md_issue_wa_i = 5'd13;
    tick();
    md_issue_i = 1'b0;
    md_wa_i = 5'd14; md_wd_i = 32'hE;
    tick();
    md_valid_i = 1'b0;
    pipe_we_i = 1'b0;
    rst_n_i = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(md_ready_o), 64'd0);
    chk("mid_rst_we", 64'(rf_we_o), 64'd0);
    tick();
    chk("mid_rst_pending", 64'(pending_o), 64'd0);
    rst_n_i = 1'b1;
    #1;
    chk("post_rst_we", 64'(rf_we_o), 64'd0);
    chk("post_rst_ready", 64'(md_ready_o), 64'd1);
    tick();
    chk("post_rst_idle", 64'(rf_we_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_regwrite_arbiter
`default_nettype wire

// File: doc/regwrite_arbiter.md
# regwrite_arbiter

Shares the single register-file write port between the in-order pipeline writeback stage and the multicycle mult/div unit, and keeps a scoreboard of destination registers with mult/div results still in flight. It sits directly in front of the register file's write port (`writeenable`/`ra3`/`wd3`). It feeds a hazard stall back to decode. The pipeline always has priority; mult/div results are buffered in a small FIFO and drained into idle write-port cycles.

## Interface
- DEPTH, 2, mult/div result FIFO entries (power of two, ≥2)
- NREG, 32, architectural registers; r0 hard-wired zero
- clk  in  1  system clock, all state on posedge
- rst_n  in  1  synchronous reset, active-low
- halt  in  1  freeze: no write, no pop, no push, scoreboard frozen
- pipe_we  in  1  pipeline writeback valid
- pipe_wa  in  5  pipeline destination register
- pipe_wd  in  32  pipeline write data
- md_issue  in  1  decode issues a mult/div op this cycle
- md_issue_wa  in  5  destination of issued mult/div op
- md_valid  in  1  mult/div result valid
- md_ready  out  1  FIFO can accept a result
- md_wa  in  5  mult/div result destination
- md_wd  in  32  mult/div result data
- chk_ra1, chk_ra2, chk_wa  in  5 each  decode-stage sources and destination
- stall  out  1  decode hazard against pending registers
- rf_we  out  1  to register file writeenable
- rf_wa  out  5  to register file ra3
- rf_wd  out  32  to register file wd3
- pending  out  NREG  scoreboard bit vector, bit 0 always 0

## Operation
- Push: md_valid && md_ready stores {md_wa, md_wd} at the FIFO tail. md_ready = !full && !halt && rst_n.
- Port select, evaluated every cycle:
  - pipe_we && pipe_wa != 0: pipeline wins. rf_we=1, rf_wa/rf_wd = pipe_wa/pipe_wd. No pop.
  - Otherwise, FIFO non-empty: pop the head. rf_we=1, rf_wa/rf_wd = head.
  - Otherwise: rf_we=0.
- A pipeline write to r0 does not use the port; the FIFO may drain that cycle.
- A FIFO head with wa=0 pops with rf_we=0.
- Scoreboard:
  - Set: md_issue && md_issue_wa != 0 sets pending[md_issue_wa].
  - Clear: a FIFO pop to register r clears pending[r].
  - Simultaneous set and clear of the same r: set wins.
- stall = pending[chk_ra1] | pending[chk_ra2] | pending[chk_wa]. Index 0 never stalls. Decode holds issue while stall is high, so WAW/RAW against in-flight mult/div results is prevented upstream.
- halt=1:
  - rf_we=0, md_ready=0, no pop.
  - Set/clear suppressed; stall still computed.
- Simultaneous push and pop: allowed in any state except empty. An entry written this cycle is not visible at the head until the next cycle.
- FIFO pointers wrap modulo DEPTH. A full/empty distinction bit or occupancy counter of log2(DEPTH)+1 bits is required.

## Timing
- Reset (rst_n=0 at posedge):
  - FIFO empty, pending=0.
  - Outputs during and after reset: md_ready=0 while rst_n=0, then 1 the cycle after release. stall=0, rf_we=0.
- Reset mid-operation discards buffered results and clears the scoreboard.
- Port path: pipe_* → rf_* is combinational, zero latency.
- Mult/div path: a result accepted at edge N is written to the register file at edge N+1 at the earliest. The pending bit reads 0 from edge N+1.
- md_ready deasserts in the cycle after the push that fills the FIFO.
- stall is combinational from chk_* and registered pending.

## Structure
- Package regwrite_pkg:
  - NREG, REG_AW=5, DATA_W=32
  - typedef struct wb_req_t {logic [4:0] wa; logic [31:0] wd;}
- Sub-module wb_fifo: DEPTH-entry synchronous FIFO of wb_req_t with push/pop/full/empty/count.
- Arbitration and scoreboard live in the top module.

## Test plan
- Reset, then idle: rf_we=0, pending=0, md_ready=1 one cycle after rst_n rises.
- md_issue r5, then md_valid {r5, 0x1234} with pipeline idle → pending[5]=1 and stall on chk_ra1=5 until the write edge. Next cycle: rf_we=1, rf_wa=5, rf_wd=0x1234, then pending[5]=0.
- pipe_we r3=0xAA for 4 cycles while two mult/div results {r7, r8} arrive → FIFO full, md_ready=0. r7 then r8 written in the two cycles after pipe_we drops.
- pipe_we with pipe_wa=0 while FIFO holds {r9, 0x55} → r9 written that cycle.
- md_issue r4 in the same cycle r4 pops from the FIFO → pending[4]=1 afterward.
- halt=1 with a FIFO entry pending → rf_we=0 and contents retained. halt=0 → write occurs next cycle. rst_n=0 while entries are buffered → FIFO empty, pending=0.
